// File: rtl/prewish_pkg.sv
// Shared constants for the prewish mask blinker: mask width, FSM encoding, MSB index.
package prewish_pkg;
  localparam int MASK_W = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] MSB_IDX = 3'd7;

  typedef logic [MASK_W-1:0] mask_t;
endpackage

// File: rtl/prewish_prescaler.sv
// Free-running bit-period prescaler: counts while enabled, ticks for one cycle at all-ones.
module prewish_prescaler #(
  parameter int PRESCALE_WIDTH = 21
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);
  logic [PRESCALE_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
    end
  end

  // A clear in the same cycle suppresses the tick, so a restart always gets a full period.
  assign o_tick = i_enable & ~i_clear & (&r_cnt);
endmodule

// File: rtl/prewish_mask_blinker.sv
// Plays an 8-bit mask on one LED, MSB first, one bit per 2^PRESCALE_WIDTH clocks, repeating.
// Build option PREWISH_BLINKER_PENDING_EN: nonzero loads while running wait for the next wrap.
module prewish_mask_blinker
  import prewish_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 21
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [MASK_W-1:0] DAT_I,
  output logic              o_led,
  output logic              o_busy,
  output logic              o_wrap
);
  // Link semantics: STB_I has no back-pressure; a load is its rising edge (STB_I high,
  // previous sample low), DAT_I is taken in that cycle, and a held strobe loads only once.
  logic [0:0] r_state;
  mask_t      r_mask;
  logic [2:0] r_idx;
  logic       r_stb_d;
  logic       r_wrap;

  logic w_load;
  logic w_zero;
  logic w_tick;
  logic w_presc_clr;
  logic w_pass_end;

  assign w_load     = STB_I & ~r_stb_d;
  assign w_zero     = (DAT_I == '0);
  assign w_pass_end = w_tick & (r_idx == '0);

`ifdef PREWISH_BLINKER_PENDING_EN
  mask_t r_pend;
  logic  r_pend_flag;
  assign w_presc_clr = (r_state == ST_IDLE) | (w_load & w_zero);
`else
  assign w_presc_clr = (r_state == ST_IDLE) | w_load;
`endif

  prewish_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_presc (
    .i_clk   (CLK_I),
    .i_rst   (RST_I),
    .i_clear (w_presc_clr),
    .i_enable(r_state == ST_RUN),
    .o_tick  (w_tick)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_idx       <= MSB_IDX;
      r_stb_d     <= 1'b0;
      r_wrap      <= 1'b0;
`ifdef PREWISH_BLINKER_PENDING_EN
      r_pend      <= '0;
      r_pend_flag <= 1'b0;
`endif
    end else begin
      r_stb_d <= STB_I;
      r_wrap  <= 1'b0;
      if (w_load && w_zero) begin
        r_state <= ST_IDLE;
        r_idx   <= MSB_IDX;
`ifdef PREWISH_BLINKER_PENDING_EN
        r_pend_flag <= 1'b0;
`endif
      end else if (w_load && (r_state == ST_IDLE)) begin
        r_state <= ST_RUN;
        r_mask  <= DAT_I;
        r_idx   <= MSB_IDX;
`ifdef PREWISH_BLINKER_PENDING_EN
      end else if (w_load) begin
        // A load landing on the wrap edge takes effect at that wrap.
        if (w_pass_end) begin
          r_mask      <= DAT_I;
          r_idx       <= MSB_IDX;
          r_wrap      <= 1'b1;
          r_pend_flag <= 1'b0;
        end else begin
          r_pend      <= DAT_I;
          r_pend_flag <= 1'b1;
          if (w_tick) r_idx <= r_idx - 3'd1;
        end
      end else if ((r_state == ST_RUN) && w_tick) begin
        r_idx <= r_idx - 3'd1;
        if (w_pass_end) begin
          r_wrap <= 1'b1;
          if (r_pend_flag) begin
            r_mask      <= r_pend;
            r_pend_flag <= 1'b0;
          end
        end
      end
`else
      end else if (w_load) begin
        r_mask <= DAT_I;
        r_idx  <= MSB_IDX;
      end else if ((r_state == ST_RUN) && w_tick) begin
        // idx is 3 bits, so 0 - 1 wraps to 7 and starts the next pass.
        r_idx <= r_idx - 3'd1;
        if (w_pass_end) r_wrap <= 1'b1;
      end
`endif
    end
  end

  assign o_busy = (r_state == ST_RUN);
  assign o_led  = (r_state == ST_RUN) & r_mask[r_idx];
  assign o_wrap = r_wrap;
endmodule

// File: tb/tb_prewish_mask_blinker.sv
// Bench for prewish_mask_blinker at PRESCALE_WIDTH=2; reference model tracks pass position in clocks.
module tb_prewish_mask_blinker;
  localparam int PW   = 2;
  localparam int PER  = 1 << PW;
  localparam int PASS = 8 * PER;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic       o_led, o_busy, o_wrap;

  int checks = 0;
  int errors = 0;

  prewish_mask_blinker #(.PRESCALE_WIDTH(PW)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .STB_I (STB_I),
    .DAT_I (DAT_I),
    .o_led (o_led),
    .o_busy(o_busy),
    .o_wrap(o_wrap)
  );

  always #5 CLK_I = ~CLK_I;

  // Reference model: m_k is clocks elapsed in the current pass (0..PASS-1).
  logic       m_run;
  logic [7:0] m_mask;
  int         m_k;
  logic       m_prev;
  logic       m_wrap;
`ifdef PREWISH_BLINKER_PENDING_EN
  logic [7:0] m_pend;
  logic       m_pflag;
`endif

  task automatic model_reset();
    m_run = 1'b0; m_mask = 8'h00; m_k = 0; m_prev = 1'b0; m_wrap = 1'b0;
`ifdef PREWISH_BLINKER_PENDING_EN
    m_pflag = 1'b0; m_pend = 8'h00;
`endif
  endtask

  task automatic model_edge(input logic stb, input logic [7:0] dat);
    logic load;
    load   = stb && !m_prev;
    m_prev = stb;
    m_wrap = 1'b0;
    if (load && dat == 8'h00) begin
      m_run = 1'b0;
`ifdef PREWISH_BLINKER_PENDING_EN
      m_pflag = 1'b0;
`endif
    end else if (load && !m_run) begin
      m_run = 1'b1; m_mask = dat; m_k = 0;
    end else if (load) begin
`ifdef PREWISH_BLINKER_PENDING_EN
      if (m_k == PASS - 1) begin
        m_mask = dat; m_k = 0; m_wrap = 1'b1; m_pflag = 1'b0;
      end else begin
        m_pend = dat; m_pflag = 1'b1; m_k = m_k + 1;
      end
`else
      m_mask = dat; m_k = 0;
`endif
    end else if (m_run) begin
      if (m_k == PASS - 1) begin
        m_k = 0; m_wrap = 1'b1;
`ifdef PREWISH_BLINKER_PENDING_EN
        if (m_pflag) begin m_mask = m_pend; m_pflag = 1'b0; end
`endif
      end else begin
        m_k = m_k + 1;
      end
    end
  endtask

  function automatic logic [2:0] expected();
    logic led;
    led = m_run ? m_mask[7 - (m_k / PER)] : 1'b0;
    return {led, m_run, m_wrap};
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle away from the edge.
  task automatic cycle(input logic stb, input logic [7:0] dat);
    STB_I = stb; DAT_I = dat;
    @(posedge CLK_I);
    if (RST_I) model_reset(); else model_edge(stb, dat);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    cycle(1'b1, 8'hFF);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00);
    #3 RST_I = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({o_led, o_busy, o_wrap} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async got %b exp 000", {o_led, o_busy, o_wrap});
    end
    cycle(1'b0, 8'h00);
    RST_I = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00);
      exp = expected();
      checks++;
      if ({o_led, o_busy, o_wrap} !== exp || exp !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got %b exp 000", i, {o_led, o_busy, o_wrap});
      end
    end
  endtask

  task automatic test_pattern();
    logic [2:0] exp;
    int wraps;
    wraps = 0;
    cycle(1'b1, 8'hA0);
    for (int i = 1; i <= 2 * PASS + 4; i++) begin
      exp = expected();
      checks++;
      if ({o_led, o_busy, o_wrap} !== exp) begin
        errors++;
        $display("FAIL pattern_a0 clk=%0d got %b exp %b", i, {o_led, o_busy, o_wrap}, exp);
      end
      if (o_wrap) wraps++;
      if (i == PASS + 1) begin
        checks++;
        if (wraps != 1) begin
          errors++;
          $display("FAIL pattern_wrap_count got %0d exp 1", wraps);
        end
      end
      cycle(1'b0, 8'hA0);
    end
  endtask

  task automatic test_held_strobe();
    logic [2:0] exp;
    cycle(1'b1, 8'h00);
    cycle(1'b0, 8'h00);
    for (int i = 0; i < PASS + 8; i++) begin
      cycle(i < 10, 8'h80);
      exp = expected();
      checks++;
      if ({o_led, o_busy, o_wrap} !== exp) begin
        errors++;
        $display("FAIL held_strobe clk=%0d got %b exp %b", i + 1, {o_led, o_busy, o_wrap}, exp);
      end
    end
  endtask

  task automatic test_midpass_load();
    logic [2:0] exp;
    cycle(1'b1, 8'h00);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hA0);
    for (int i = 0; i < 2 * PER; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hFF);
    for (int i = 0; i < PASS + 8; i++) begin
      exp = expected();
      checks++;
      if ({o_led, o_busy, o_wrap} !== exp) begin
        errors++;
        $display("FAIL midpass_load clk=%0d got %b exp %b", i, {o_led, o_busy, o_wrap}, exp);
      end
      cycle(1'b0, 8'h00);
    end
  endtask

  task automatic test_zero_load();
    logic [2:0] exp;
    cycle(1'b1, 8'hA0);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h0F);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h00);
    for (int i = 0; i < PASS + 8; i++) begin
      exp = expected();
      checks++;
      if ({o_led, o_busy, o_wrap} !== exp || exp !== 3'b000) begin
        errors++;
        $display("FAIL zero_load clk=%0d got %b exp 000", i, {o_led, o_busy, o_wrap});
      end
      cycle(1'b0, 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    int guard;
    cycle(1'b1, 8'h80);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h01);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h02);
    cycle(1'b0, 8'h00);
    guard = 0;
    while (m_k != PASS - 1 && guard < 2 * PASS) begin
      cycle(1'b0, 8'h00);
      guard++;
    end
    checks++;
    if (guard >= 2 * PASS) begin
      errors++;
      $display("FAIL b2b_wrap_timeout got k=%0d exp %0d", m_k, PASS - 1);
    end
    cycle(1'b1, 8'h04);
    for (int i = 0; i < 2 * PASS + 4; i++) begin
      exp = expected();
      checks++;
      if ({o_led, o_busy, o_wrap} !== exp) begin
        errors++;
        $display("FAIL back_to_back clk=%0d got %b exp %b", i, {o_led, o_busy, o_wrap}, exp);
      end
      cycle(1'b0, 8'h00);
    end
  endtask

  task automatic test_random();
    logic [2:0] exp;
    logic       stb;
    logic [7:0] dat;
    stb = 1'b0;
    dat = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if (stb) stb = ($urandom_range(0, 2) == 0);
      else     stb = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) dat = 8'h00;
      else dat = 8'($urandom_range(0, 255));
      cycle(stb, dat);
      exp = expected();
      checks++;
      if ({o_led, o_busy, o_wrap} !== exp) begin
        errors++;
        $display("FAIL random clk=%0d got %b exp %b", i, {o_led, o_busy, o_wrap}, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    RST_I = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b0;
    test_reset();
    test_pattern();
    test_held_strobe();
    test_midpass_load();
    test_zero_load();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
